pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the program counter and sequences next-PC selection for the single-cycle/multi-cycle core: sequential, relative jump (26-bit immediate), conditional branch (16-bit immediate), register jump, and halt. Sits between decode and instruction memory. Consumes raw immediates and sign-extends them internally. Provides stall handling, a one-cycle flush pulse on every redirect, and a saturating redirect counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, word address loaded into pc on reset
CNT_W, 16, width of redirect counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  decode holds a valid instruction for current pc
ctrl_op  in  3  000 SEQ, 001 J, 010 JR, 011 BR, 100 HALT, others treated as SEQ
branch_cond  in  1  BR condition result from ALU; ignored unless ctrl_op=BR
imm_j  in  26  J-type immediate, signed word offset
imm_b  in  16  branch immediate, signed word offset
reg_target  in  32  JR target word address
stall  in  1  hold pc this cycle (memory/hazard)
resume  in  1  leave HALTED
pc  out  32  current word address
pc_valid  out  1  pc is a fetch request
flush  out  1  one-cycle pulse: discard the instruction fetched after a redirect
halted  out  1  high in HALTED
redirect_cnt  out  CNT_W  taken-redirect count, saturating

Behaviour:
- FSM states: BOOT, RUN, STALL, HALTED.
- Reset (async, any time incl. mid-stall/halt): state=BOOT, pc=RESET_PC, pc_valid=0, flush=0, halted=0, redirect_cnt=0.
- BOOT: one cycle, then RUN; pc unchanged; pc_valid=1 from the first RUN cycle.
- RUN, stall=1: pc held, go to STALL; no ctrl_op evaluated, no flush, no count.
- RUN, stall=0, instr_valid=0: pc held, stay RUN.
- RUN, stall=0, instr_valid=1, next pc per ctrl_op, registered on the same edge (1-cycle latency):
  - SEQ: pc+1.
  - J: pc+1+sext32(imm_j); bit 25 replicated into bits 31:26.
  - JR: reg_target.
  - BR: branch_cond ? pc+1+sext32(imm_b) : pc+1.
  - HALT: pc+1 stored, go to HALTED.
- Redirect = J, JR, or BR taken. On a redirect, flush=1 for exactly the following cycle and redirect_cnt+1, saturating at all-ones (no wrap).
- BR not taken: no flush, no count.
- STALL: pc held, pc_valid=1; return to RUN on the first cycle with stall=0, with no instruction evaluated on that edge.
- HALTED: pc held, pc_valid=0, halted=1; stall ignored; resume=1 -> RUN next cycle with pc_valid=1. resume is ignored in every other state.
- Arithmetic: all adds are 32-bit modulo 2^32. 32'hFFFF_FFFF+1 = 0. Negative offsets wrap below 0.
- Simultaneous events:
  - stall beats any ctrl_op, including HALT.
  - A flush pulse already scheduled still fires when stall rises on the next cycle.
  - reset beats everything.

Decomposition:
- Shared package (cpu_pkg): ctrl_op encodings (OP_SEQ, OP_J, OP_JR, OP_BR, OP_HALT) and the FSM state enum.
- One natural sub-module: pc_target_calc. It is combinational: given pc, the immediates, reg_target, ctrl_op and branch_cond, it returns next_pc and is_redirect. Sign extension lives there.
- The FSM, pc register, flush register and counter stay in pc_sequencer.

Test Plan:
- Reset with RESET_PC=0x100 -> pc=0x100, pc_valid=0. After BOOT, pc_valid=1. Then 3 SEQ ops -> pc=0x101, 0x102, 0x103.
- pc=0x200, J with imm_j=26'h3FFFFFE (−2) -> pc=0x1FF, flush=1 for one cycle, redirect_cnt=1. Then J imm_j=26'h0000010 -> pc=0x210.
- pc=0x50: BR, cond=0, imm_b=16'h0010 -> pc=0x51, no flush. Then BR, cond=1, imm_b=16'hFFF0 -> pc=0x42, flush=1.
- pc=0x30, stall held 3 cycles alongside JR reg_target=0x900 -> pc stays 0x30. After stall drops, one idle cycle, then JR -> pc=0x900.
- HALT at pc=0x7 -> halted=1, pc=0x8, pc_valid=0. resume -> RUN, pc_valid=1. Assert reset during HALTED -> BOOT, pc=RESET_PC immediately (async).
- pc=0xFFFFFFFF, SEQ -> pc=0x0. With CNT_W=2, 5 taken redirects -> redirect_cnt saturates at 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared control-op encodings and sequencer FSM states
// Purpose: common typedefs imported by the pc sequencer slice.
// Contents: ctrl_op_e (decode control-op encodings), state_e (sequencer FSM states).
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_J    = 3'b001,
    OP_JR   = 3'b010,
    OP_BR   = 3'b011,
    OP_HALT = 3'b100
  } ctrl_op_e;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/fetch side bundle of the pc sequencer
// Purpose: groups the sequencer's control inputs and fetch outputs.
// Ports (slave view, i.e. the sequencer):
//   in : instr_valid, ctrl_op[2:0], branch_cond, imm_j[25:0], imm_b[15:0],
//        reg_target[31:0], stall, resume
//   out: pc[31:0], pc_valid, flush, halted, redirect_cnt[CNT_W-1:0]
interface pc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [2:0]       ctrl_op;
  logic             branch_cond;
  logic [25:0]      imm_j;
  logic [15:0]      imm_b;
  logic [31:0]      reg_target;
  logic             stall;
  logic             resume;
  logic [31:0]      pc;
  logic             pc_valid;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output instr_valid, ctrl_op, branch_cond, imm_j, imm_b, reg_target, stall, resume,
    input  pc, pc_valid, flush, halted, redirect_cnt
  );

  modport slave (
    input  instr_valid, ctrl_op, branch_cond, imm_j, imm_b, reg_target, stall, resume,
    output pc, pc_valid, flush, halted, redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// rtl/pc_sequencer_target_calc.sv - combinational next-pc and redirect decode
// Purpose: computes the candidate next pc for the current ctrl_op.
// Ports:
//   in : pc[31:0], ctrl_op[2:0], branch_cond, imm_j[25:0], imm_b[15:0], reg_target[31:0]
//   out: next_pc[31:0], is_redirect (J, JR, or taken BR)
module pc_target_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  ctrl_op,
  input  logic        branch_cond,
  input  logic [25:0] imm_j,
  input  logic [15:0] imm_b,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        is_redirect
);
  logic [31:0] pc_plus1;
  logic [31:0] sext_j;
  logic [31:0] sext_b;

  // Offsets are relative to pc+1; all sums wrap modulo 2^32.
  assign pc_plus1 = pc + 32'd1;
  assign sext_j   = {{6{imm_j[25]}}, imm_j};
  assign sext_b   = {{16{imm_b[15]}}, imm_b};

  always_comb begin
    next_pc     = pc_plus1;
    is_redirect = 1'b0;
    case (ctrl_op)
      OP_J: begin
        next_pc     = pc_plus1 + sext_j;
        is_redirect = 1'b1;
      end
      OP_JR: begin
        next_pc     = reg_target;
        is_redirect = 1'b1;
      end
      OP_BR: begin
        if (branch_cond) begin
          next_pc     = pc_plus1 + sext_b;
          is_redirect = 1'b1;
        end
      end
      // SEQ, HALT and unused encodings all advance sequentially.
      default: begin
        next_pc     = pc_plus1;
        is_redirect = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and next-pc sequencer
// Purpose: holds pc, runs the BOOT/RUN/STALL/HALTED FSM, emits a one-cycle
//          flush after every redirect and counts redirects (saturating).
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : pc_sequencer_if.slave (decode controls in, fetch pc/status out)
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  pc_sequencer_if.slave        bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  state_e           state_d;
  logic [31:0]      pc_q;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      next_pc;
  logic             is_redirect;
  logic             advance;

  pc_target_calc u_calc (
    .pc          (pc_q),
    .ctrl_op     (bus.ctrl_op),
    .branch_cond (bus.branch_cond),
    .imm_j       (bus.imm_j),
    .imm_b       (bus.imm_b),
    .reg_target  (bus.reg_target),
    .next_pc     (next_pc),
    .is_redirect (is_redirect)
  );

  // An instruction is only consumed in RUN with no stall; the edge leaving
  // STALL deliberately evaluates nothing.
  assign advance = (state_q == ST_RUN) && !bus.stall && bus.instr_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN: begin
        if (bus.stall)
          state_d = ST_STALL;
        else if (bus.instr_valid && (bus.ctrl_op == OP_HALT))
          state_d = ST_HALTED;
      end
      ST_STALL:  if (!bus.stall) state_d = ST_RUN;
      ST_HALTED: if (bus.resume) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    bus.pc_valid = (state_q == ST_RUN) || (state_q == ST_STALL);
    bus.halted   = (state_q == ST_HALTED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // flush is a pure one-cycle echo of the redirect edge, independent of
      // whatever stall does in the following cycle.
      flush_q <= advance && is_redirect;
      if (advance)
        pc_q <= next_pc;
      if (advance && is_redirect && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.flush        = flush_q;
  assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed table-driven bench for pc_sequencer
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  pc_sequencer_if #(.CNT_W(2)) bus ();

  pc_sequencer #(.RESET_PC(32'h0000_0100), .CNT_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  op;
    logic        bc;
    logic [25:0] ij;
    logic [15:0] ib;
    logic [31:0] rt;
    logic        st;
    logic        rs;
    logic [31:0] e_pc;
    logic        e_pv;
    logic        e_fl;
    logic        e_ha;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [2:0] op, logic bc, logic [25:0] ij,
                              logic [15:0] ib, logic [31:0] rt, logic st, logic rs,
                              logic [31:0] e_pc, logic e_pv, logic e_fl, logic e_ha,
                              logic [1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.op = op; v.bc = bc; v.ij = ij; v.ib = ib; v.rt = rt;
    v.st = st; v.rs = rs; v.e_pc = e_pc; v.e_pv = e_pv; v.e_fl = e_fl;
    v.e_ha = e_ha; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic [2:0] op, logic bc, logic [25:0] ij,
                       logic [15:0] ib, logic [31:0] rt, logic st, logic rs);
    bus.instr_valid = iv; bus.ctrl_op = op; bus.branch_cond = bc; bus.imm_j = ij;
    bus.imm_b = ib; bus.reg_target = rt; bus.stall = st; bus.resume = rs;
  endtask

  task automatic check_all(string tag, logic [31:0] e_pc, logic e_pv, logic e_fl,
                           logic e_ha, logic [1:0] e_cnt);
    check({tag, ".pc"},       bus.pc,                   e_pc);
    check({tag, ".pc_valid"}, {31'd0, bus.pc_valid},    {31'd0, e_pv});
    check({tag, ".flush"},    {31'd0, bus.flush},       {31'd0, e_fl});
    check({tag, ".halted"},   {31'd0, bus.halted},      {31'd0, e_ha});
    check({tag, ".cnt"},      {30'd0, bus.redirect_cnt}, {30'd0, e_cnt});
  endtask

  initial begin
    // inputs: iv op bc imm_j imm_b reg_target stall resume | expected pc pv fl ha cnt
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h100,      1, 0, 0, 0)); // 0 first RUN cycle
    vecs.push_back(mk(1, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h101,      1, 0, 0, 0)); // 1
    vecs.push_back(mk(1, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h102,      1, 0, 0, 0)); // 2
    vecs.push_back(mk(1, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h103,      1, 0, 0, 0)); // 3
    vecs.push_back(mk(0, OP_J,    0, 26'h5,       16'h0,    32'h0,        0, 0, 32'h103,      1, 0, 0, 0)); // 4 no valid -> hold
    vecs.push_back(mk(1, 3'b111,  1, 26'h5,       16'h5,    32'h0,        0, 0, 32'h104,      1, 0, 0, 0)); // 5 unused op = SEQ
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h200,      0, 0, 32'h200,      1, 1, 0, 1)); // 6
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h200,      1, 0, 0, 1)); // 7
    vecs.push_back(mk(1, OP_J,    0, 26'h3FFFFFE, 16'h0,    32'h0,        0, 0, 32'h1FF,      1, 1, 0, 2)); // 8 J -2
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h1FF,      1, 0, 0, 2)); // 9
    vecs.push_back(mk(1, OP_J,    0, 26'h0000010, 16'h0,    32'h0,        0, 0, 32'h210,      1, 1, 0, 3)); // 10
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h210,      1, 0, 0, 3)); // 11
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h50,       0, 0, 32'h50,       1, 1, 0, 3)); // 12 saturate
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h50,       1, 0, 0, 3)); // 13
    vecs.push_back(mk(1, OP_BR,   0, 26'h0,       16'h0010, 32'h0,        0, 0, 32'h51,       1, 0, 0, 3)); // 14 BR not taken
    vecs.push_back(mk(1, OP_BR,   1, 26'h0,       16'hFFF0, 32'h0,        0, 0, 32'h42,       1, 1, 0, 3)); // 15 BR taken -16
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h30,       0, 0, 32'h30,       1, 1, 0, 3)); // 16
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h900,      1, 0, 32'h30,       1, 0, 0, 3)); // 17 stall
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h900,      1, 0, 32'h30,       1, 0, 0, 3)); // 18
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h900,      1, 0, 32'h30,       1, 0, 0, 3)); // 19
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h900,      0, 0, 32'h30,       1, 0, 0, 3)); // 20 leave STALL, no eval
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h900,      0, 0, 32'h900,      1, 1, 0, 3)); // 21
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'h7,        0, 0, 32'h7,        1, 1, 0, 3)); // 22
    vecs.push_back(mk(1, OP_HALT, 0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h8,        0, 0, 1, 3)); // 23 HALT
    vecs.push_back(mk(1, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        1, 0, 32'h8,        0, 0, 1, 3)); // 24 stall ignored
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 1, 32'h8,        1, 0, 0, 3)); // 25 resume
    vecs.push_back(mk(1, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 1, 32'h9,        1, 0, 0, 3)); // 26 resume ignored in RUN
    vecs.push_back(mk(1, OP_HALT, 0, 26'h0,       16'h0,    32'h0,        1, 0, 32'h9,        1, 0, 0, 3)); // 27 stall beats HALT
    vecs.push_back(mk(0, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h9,        1, 0, 0, 3)); // 28
    vecs.push_back(mk(1, OP_JR,   0, 26'h0,       16'h0,    32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 3)); // 29
    vecs.push_back(mk(1, OP_SEQ,  0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h0,        1, 0, 0, 3)); // 30 wrap to 0
    vecs.push_back(mk(1, OP_BR,   1, 26'h0,       16'hFFFE, 32'h0,        0, 0, 32'hFFFFFFFF, 1, 1, 0, 3)); // 31 wrap below 0
    vecs.push_back(mk(1, OP_J,    0, 26'h1FFFFFF, 16'h0,    32'h0,        0, 0, 32'h01FFFFFF, 1, 1, 0, 3)); // 32 max positive J
    vecs.push_back(mk(1, OP_HALT, 0, 26'h0,       16'h0,    32'h0,        0, 0, 32'h02000000, 0, 0, 1, 3)); // 33

    drive(0, OP_SEQ, 0, 26'h0, 16'h0, 32'h0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all("reset", 32'h100, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check_all("boot", 32'h100, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].iv, vecs[i].op, vecs[i].bc, vecs[i].ij, vecs[i].ib, vecs[i].rt,
            vecs[i].st, vecs[i].rs);
      @(posedge clock);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pv, vecs[i].e_fl,
                vecs[i].e_ha, vecs[i].e_cnt);
    end

    // Asynchronous reset while HALTED takes effect without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 32'h100, 0, 0, 0, 0);
    @(negedge clock);
    drive(0, OP_SEQ, 0, 26'h0, 16'h0, 32'h0, 0, 0);
    reset = 1'b0;
    #1;
    check_all("reboot", 32'h100, 0, 0, 0, 0);

    // A scheduled flush still fires when stall rises in the next cycle.
    @(negedge clock);
    drive(1, OP_JR, 0, 26'h0, 16'h0, 32'h40, 0, 0);
    @(posedge clock);
    #1;
    check_all("jr_after_reset", 32'h40, 1, 1, 0, 1);
    @(negedge clock);
    drive(1, OP_J, 0, 26'h8, 16'h0, 32'h0, 1, 0);
    #1;
    check_all("flush_with_stall", 32'h40, 1, 1, 0, 1);
    @(posedge clock);
    #1;
    check_all("stall_after_flush", 32'h40, 1, 0, 0, 1);
    @(negedge clock);
    drive(0, OP_SEQ, 0, 26'h0, 16'h0, 32'h0, 0, 0);
    @(posedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
